// File: rtl/sw_event_scheduler_pkg.sv
// Shared types and constants for the switch event scheduler.
package sw_sched_pkg;

   localparam int NUM_BITS_DEF = 18;

   typedef enum logic [1:0] {
      SETTLE  = 2'd0,
      IDLE    = 2'd1,
      PRESENT = 2'd2
   } state_e;

   function automatic int calc_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sw_event_scheduler_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping to bit 0.
module rr_pick
   import sw_sched_pkg::*;
#(
   parameter int N  = NUM_BITS_DEF,
   parameter int IW = calc_idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   localparam int PW = IW + 1;
   localparam logic [2*N-1:0] DBL_ONE = {{(2*N-1){1'b0}}, 1'b1};

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] below;
   logic [2*N-1:0] masked;
   logic [PW-1:0]  pos;

   // The upper copy of the mask supplies the wrapped-around candidates.
   always_comb begin
      dbl    = {req, req};
      below  = (DBL_ONE << ptr) - DBL_ONE;
      masked = dbl & ~below;
      pos    = '0;
      for (int i = 2*N-1; i >= 0; i--) begin
         if (masked[i]) pos = PW'(i);
      end
      found = |req;
      idx   = (pos >= PW'(N)) ? IW'(pos - PW'(N)) : pos[IW-1:0];
   end

endmodule

// File: rtl/sw_event_scheduler.sv
// Serialises per-switch change pulses into a round-robin event stream.
module sw_event_scheduler
   import sw_sched_pkg::*;
#(
   parameter  int NUM_BITS      = NUM_BITS_DEF,
   parameter  int SETTLE_CYCLES = 2,
   localparam int IDX_W         = calc_idx_w(NUM_BITS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_BITS-1:0] SW_edge_det,
   input  logic [NUM_BITS-1:0] SW_level,
   input  logic                event_ready,
   output logic                event_valid,
   output logic [IDX_W-1:0]    event_idx,
   output logic                event_level,
   output logic [NUM_BITS-1:0] pending,
   output logic                overflow
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_BITS - 1);

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NUM_BITS-1:0]   pending_q, pending_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                  valid_q, valid_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  level_q, level_d;
   logic                  ovf_q, ovf_d;

   logic [IDX_W-1:0]      next_ptr, pick_ptr, pick_idx;
   logic                  pick_found, grant, accept;
   logic [NUM_BITS-1:0]   clear_mask;

   assign next_ptr = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
   assign pick_ptr = (state_q == PRESENT) ? next_ptr : rr_ptr_q;

   rr_pick #(.N(NUM_BITS), .IW(IDX_W)) u_pick (
      .req   (pending_q),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Handshake: an event transfers on a rising edge where event_valid and
   // event_ready are both 1; while valid and not ready, idx/level hold.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pending_d  = pending_q;
      rr_ptr_d   = rr_ptr_q;
      valid_d    = valid_q;
      idx_d      = idx_q;
      level_d    = level_q;
      ovf_d      = ovf_q;
      grant      = 1'b0;
      clear_mask = '0;
      accept     = valid_q & event_ready;

      case (state_q)
         SETTLE: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (pick_found) grant = 1'b1;
         end
         PRESENT: begin
            if (accept) begin
               rr_ptr_d = next_ptr;
               if (pick_found) begin
                  grant = 1'b1;
               end else begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = SETTLE;
      endcase

      if (grant) begin
         clear_mask = NUM_BITS'(1) << pick_idx;
         valid_d    = 1'b1;
         idx_d      = pick_idx;
         level_d    = SW_level[pick_idx];
         state_d    = PRESENT;
      end

      // A pulse on the bit being granted this cycle re-arms it rather than overflowing.
      if (state_q != SETTLE) begin
         pending_d = (pending_q & ~clear_mask) | SW_edge_det;
         ovf_d     = ovf_q | (|(SW_edge_det & pending_q & ~clear_mask));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= SETTLE;
         cnt_q     <= '0;
         pending_q <= '0;
         rr_ptr_q  <= '0;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         level_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         rr_ptr_q  <= rr_ptr_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         level_q   <= level_d;
         ovf_q     <= ovf_d;
      end
   end

   assign event_valid = valid_q;
   assign event_idx   = idx_q;
   assign event_level = level_q;
   assign pending     = pending_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_sw_event_scheduler.sv
// Bench for sw_event_scheduler: directed scenarios plus random traffic against a reference model.
module tb_sw_event_scheduler;
   import sw_sched_pkg::*;

   localparam int N      = 18;
   localparam int IW     = 5;
   localparam int SETTLE_N = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  sw_edge = '0;
   logic [N-1:0]  sw_level = '0;
   logic          event_ready = 1'b0;
   logic          event_valid;
   logic [IW-1:0] event_idx;
   logic          event_level;
   logic [N-1:0]  pending;
   logic          overflow;

   sw_event_scheduler #(.NUM_BITS(N), .SETTLE_CYCLES(SETTLE_N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .SW_edge_det (sw_edge),
      .SW_level    (sw_level),
      .event_ready (event_ready),
      .event_valid (event_valid),
      .event_idx   (event_idx),
      .event_level (event_level),
      .pending     (pending),
      .overflow    (overflow)
   );

   // clock
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [IW:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending set, pointer, presented event, sticky overflow.
   bit [N-1:0] m_pend;
   int         m_ptr, m_idx, m_cnt;
   bit         m_settled, m_valid, m_ovf;

   function automatic int rr_find(input bit [N-1:0] p, input int start);
      for (int k = 0; k < N; k++) begin
         if (p[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk) begin : model
      bit [N-1:0] old_p;
      bit [N-1:0] new_p;
      bit         gnt;
      int         g;
      if (!rst_n) begin
         m_pend = '0; m_ptr = 0; m_idx = 0; m_cnt = 0;
         m_settled = 0; m_valid = 0; m_ovf = 0;
         exp_q.delete();
      end else if (!m_settled) begin
         m_cnt++;
         if (m_cnt >= SETTLE_N) m_settled = 1;
      end else begin
         old_p = m_pend;
         gnt   = 0;
         g     = -1;
         if (!m_valid) begin
            if (old_p != 0) begin g = rr_find(old_p, m_ptr); gnt = 1; end
         end else if (event_ready) begin
            m_ptr = (m_idx + 1) % N;
            if (old_p != 0) begin g = rr_find(old_p, m_ptr); gnt = 1; end
            else m_valid = 0;
         end
         new_p = old_p;
         if (gnt) begin
            new_p[g] = 1'b0;
            m_valid  = 1;
            m_idx    = g;
            exp_q.push_back({sw_level[g], IW'(g)});
         end
         for (int i = 0; i < N; i++) begin
            if (sw_edge[i] && old_p[i] && !(gnt && g == i)) m_ovf = 1;
         end
         m_pend = new_p | sw_edge;
      end
   end

   // Monitor: pops one expectation per new presentation, checks it while held.
   logic [IW:0] cur_exp = '0;
   bit          prev_valid = 0;
   bit          prev_acc = 0;

   always @(negedge clk) begin : monitor
      check("event_valid", 32'(event_valid), 32'(m_valid));
      check("pending", 32'(pending), 32'(m_pend));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (event_valid) begin
         if (!prev_valid || prev_acc) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_event: got idx %0d with no expected event at %0t",
                        event_idx, $time);
            end else begin
               cur_exp = exp_q.pop_front();
            end
         end
         check("event_data", 32'({event_level, event_idx}), 32'(cur_exp));
      end
      prev_valid = event_valid;
      prev_acc   = event_valid && event_ready;
   end

   // driver tasks
   task automatic step(input logic [N-1:0] e, input logic [N-1:0] lv, input logic rdy);
      sw_edge     = e;
      sw_level    = lv;
      event_ready = rdy;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step('0, sw_level, rdy);
   endtask

   function automatic logic [N-1:0] bits(input int a, input int b, input int c);
      logic [N-1:0] v;
      v = '0;
      if (a >= 0) v[a] = 1'b1;
      if (b >= 0) v[b] = 1'b1;
      if (c >= 0) v[c] = 1'b1;
      return v;
   endfunction

   initial begin
      logic [N-1:0] lv;
      logic [N-1:0] e;

      rst_n = 1'b0;
      idle(3, 1'b0);
      check("reset_state", 32'(dut.state_q), 32'(SETTLE));
      check("reset_valid", 32'(event_valid), 32'd0);
      check("reset_idx", 32'(event_idx), 32'd0);
      rst_n = 1'b1;

      // settle window: pulses on edges 1 and 2 are dropped, edge 3 is latched
      step(bits(5, -1, -1), '0, 1'b1);
      step(bits(5, -1, -1), '0, 1'b1);
      check("settle_no_pending", 32'(pending), 32'd0);
      check("settle_no_ovf", 32'(overflow), 32'd0);
      step(bits(5, -1, -1), '0, 1'b1);
      check("settle_latched", 32'(pending), 32'(bits(5, -1, -1)));
      idle(1, 1'b1);
      check("settle_event_valid", 32'(event_valid), 32'd1);
      check("settle_event_idx", 32'(event_idx), 32'd5);
      idle(3, 1'b1);

      // single event with level capture
      lv = bits(3, -1, -1);
      step(bits(3, -1, -1), lv, 1'b1);
      idle(4, 1'b1);

      // round-robin with wrap
      step(bits(0, 7, 17), sw_level, 1'b0);
      idle(3, 1'b0);
      idle(4, 1'b1);
      step(bits(17, 2, -1), sw_level ^ bits(2, 17, -1), 1'b1);
      idle(4, 1'b1);

      // backpressure with level toggling, plus coalesced overflow on bit 9
      step(bits(4, -1, -1), sw_level, 1'b0);
      idle(2, 1'b0);
      step(bits(9, -1, -1), sw_level, 1'b0);
      idle(1, 1'b0);
      step(bits(9, -1, -1), sw_level, 1'b0);
      check("overflow_set", 32'(overflow), 32'd1);
      for (int i = 0; i < 10; i++) step('0, sw_level ^ bits(4, -1, -1), 1'b0);
      check("bp_idx_held", 32'(event_idx), 32'd4);
      idle(5, 1'b1);

      // reset mid-operation
      step(bits(1, -1, -1), sw_level, 1'b0);
      idle(2, 1'b0);
      step(N'(18'h000F0), sw_level, 1'b0);
      idle(1, 1'b0);
      check("midrst_pending_before", 32'(pending), 32'h000F0);
      check("midrst_valid_before", 32'(event_valid), 32'd1);
      rst_n = 1'b0;
      idle(1, 1'b0);
      check("midrst_state", 32'(dut.state_q), 32'(SETTLE));
      check("midrst_valid", 32'(event_valid), 32'd0);
      check("midrst_pending", 32'(pending), 32'd0);
      check("midrst_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      idle(8, 1'b1);
      check("midrst_no_stale", 32'(event_valid), 32'd0);

      // random traffic with occasional resets
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < N; b++) e[b] = ($urandom_range(0, 11) == 0);
         lv    = N'($urandom());
         rst_n = ($urandom_range(0, 299) != 0);
         step(e, lv, ($urandom_range(0, 9) < 7));
      end
      rst_n = 1'b1;
      idle(60, 1'b1);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sw_event_scheduler.md
Name: sw_event_scheduler

Overview:
- Arbitrates per-switch change pulses from the switch edge detector into a single serialized event stream.
- Latches every pulse into a pending mask, picks one pending switch per grant in round-robin order, and presents its index and current level on a valid/ready handshake.
- Sits between the switch edge detector and the command/FSM logic, so downstream logic handles one switch change at a time.
- Also masks the detector's start-up settling window after reset.

Parameters:
- NUM_BITS, 18, number of switch channels.
- IDX_W, $clog2(NUM_BITS), width of the event index (derived; not overridden).
- SETTLE_CYCLES, 2, cycles after reset release during which incoming pulses are discarded.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- SW_edge_det  input  NUM_BITS  one-cycle change pulse per switch.
- SW_level  input  NUM_BITS  current switch levels, sampled when an event is granted.
- event_ready  input  1  consumer accepts the presented event.
- event_valid  output  1  an event is presented.
- event_idx  output  IDX_W  switch index of the presented event.
- event_level  output  1  level of that switch captured at grant (1 = rising, 0 = falling).
- pending  output  NUM_BITS  pending mask (debug/LED use).
- overflow  output  1  sticky: a pulse arrived on a bit already pending.

Behaviour:
- Reset (rst_n=0 at a clk edge), all of:
  - state=SETTLE, settle counter=0, pending=0, rr_ptr=0.
  - event_valid=0, event_idx=0, event_level=0, overflow=0.
- SETTLE:
  - SW_edge_det is ignored (not latched, no overflow).
  - The counter increments each cycle.
  - After SETTLE_CYCLES cycles → IDLE.
  - With the default, the first cycle in which a pulse can be latched is the 3rd rising edge after rst_n goes high.
- Pending latch (IDLE and PRESENT):
  - pending_next = (pending & ~clear_mask) | SW_edge_det.
  - clear_mask is the one-hot of the granted index in the cycle it is granted.
  - If SW_edge_det[i]=1 while pending[i]=1 and i is not being cleared that cycle, set overflow. The event is coalesced, not duplicated.
  - overflow clears only on reset.
- IDLE:
  - If pending≠0, grant the first set bit searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, …, NUM_BITS-1, 0, …, rr_ptr-1).
  - On the grant, register event_idx=granted index and event_level=SW_level[granted].
  - On the grant, clear pending[granted] and set event_valid=1 → PRESENT.
  - Latency: a pulse on an idle channel gives event_valid=1 two clock edges after the pulse cycle (one edge to latch into pending, one edge to grant).
  - Pulses arriving in the grant cycle are only seen next cycle.
- PRESENT:
  - event_valid, event_idx and event_level stay stable until event_ready=1 is sampled.
  - On accept:
    - rr_ptr = (event_idx+1) wrapping NUM_BITS-1 → 0.
    - If pending (post-update) ≠ 0, grant the next event in the same cycle and stay in PRESENT (back-to-back, one event per cycle).
    - Otherwise event_valid=0 → IDLE.
  - A new pulse on the bit currently presented sets pending[idx] again. It is a new event, not overflow.
- event_ready while event_valid=0 is ignored.
- Simultaneous pulses on several bits are all latched; they are served one per accept in round-robin order.
- rst_n=0 in any state discards the presented and pending events, returns to SETTLE, and drives event_valid=0 on the next edge.
- Fairness: every pending bit is served within NUM_BITS accepts.

Decomposition:
- Package sw_sched_pkg holds:
  - state enum {SETTLE, IDLE, PRESENT} as a 2-bit logic typedef;
  - the default NUM_BITS constant;
  - a function computing IDX_W.
- Sub-module rr_pick (combinational):
  - inputs: req mask, rr_ptr;
  - outputs: found, index of the first set bit at or above the pointer with wrap;
  - implement with a doubled mask/priority encoder.
- The top holds the FSM, pending register, settle counter and output registers.

Test Plan:
- Settle mask: release reset, pulse bit 5 in cycles 1 and 2 after release → no event_valid and overflow=0; pulse bit 5 in cycle 3 → event_valid=1, event_idx=5 two edges later.
- Single event with latency: event_ready=1, SW_level[3]=1, pulse bit 3 once → event_valid high for exactly 1 cycle, 2 edges after the pulse, event_idx=3, event_level=1; pending returns to 0.
- Round-robin with wrap: event_ready=0, pulse bits 0, 7 and 17 together; accept one per cycle → order 0, 7, 17; then pulse bits 17 and 2 together (rr_ptr=0 after the wrap) → order 2, 17.
- Backpressure stability: hold event_ready=0 for 10 cycles with bit 4 presented and toggle SW_level[4] → event_idx and event_level unchanged; assert ready → next pending event on the following cycle, or event_valid=0 if none.
- Overflow and coalesce: event_ready=0, pulse bit 9 twice while it is pending but not presented → overflow=1 and only one event for index 9 is delivered.
- Reset mid-operation: pending=0x00F0, event_valid=1; drive rst_n=0 for one edge → next edge event_valid=0, pending=0, overflow=0, state SETTLE; no stale events after settling.
